// File: rtl/seg_scan_if.sv
// Interface between the scan driver, the upstream segment encoders and the
// display pin drivers: pattern writes, scan control, and the display outputs.
interface seg_scan_if;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] bright;
    logic [7:0] seg_data;
    logic [7:0] seg_com;
    logic       frame_tick;

    modport master (
        output en, wr_en, wr_addr, wr_data, bright,
        input  seg_data, seg_com, frame_tick
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, bright,
        output seg_data, seg_com, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-cathode 7-segment scan driver: per-digit pattern file,
// per-slot shadow latch, blanking gap, 3-bit brightness duty and a frame marker.
module seg_scan_driver #(
    parameter int CLK_DIV = 1000,
    parameter int BLANK   = 16,
    parameter int DIGITS  = 8
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_DIG = 3'(DIGITS - 1);
    localparam logic [15:0]   QUANTUM  = 16'((CLK_DIV - BLANK) >> 3);
    localparam logic [31:0]   BLANK_U  = 32'(BLANK);

    logic [CW-1:0] r_slot_cnt;
    logic [2:0]    r_dig;
    logic [7:0]    r_file [8];
    logic [7:0]    r_cur_pat;
    logic [15:0]   r_cur_on;
    logic [7:0]    r_seg_data;
    logic [7:0]    r_seg_com;
    logic          r_frame_tick;

    logic          w_wr_ok;
    logic          w_slot_start;
    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_lit;
    logic [15:0]   w_on_len;
    logic [31:0]   w_cnt_ext;
    logic [7:0]    w_seg_data_nx;
    logic [7:0]    w_seg_com_nx;

    assign w_wr_ok      = bus.wr_en && (int'(bus.wr_addr) < DIGITS);
    assign w_slot_start = bus.en && (r_slot_cnt == '0);
    assign w_slot_end   = (r_slot_cnt == LAST_CNT);
    assign w_frame_end  = w_slot_end && (r_dig == LAST_DIG);
    assign w_on_len     = QUANTUM * ({13'd0, bus.bright} + 16'd1);
    assign w_cnt_ext    = 32'(r_slot_cnt);
    assign w_lit        = bus.en && (w_cnt_ext >= BLANK_U)
                          && (w_cnt_ext < BLANK_U + {16'd0, r_cur_on});

    // NOTE: defaults first so every path assigns both signals; no latch is inferred.
    always_comb begin
        w_seg_data_nx = '0;
        w_seg_com_nx  = '1;
        if (w_lit) begin
            w_seg_data_nx = r_cur_pat;
            w_seg_com_nx  = ~(8'd1 << r_dig);
        end
    end

    // NOTE: the pattern file is reset because a cleared display after reset is
    // visible behaviour; a plain data RAM would normally be left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) r_file[i] <= '0;
        end else if (w_wr_ok) begin
            r_file[bus.wr_addr] <= bus.wr_data;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // which is also what makes a same-edge write reach the shadow one visit later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_dig      <= '0;
        end else if (!bus.en) begin
            r_slot_cnt <= '0;
            r_dig      <= '0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_dig      <= (r_dig == LAST_DIG) ? 3'd0 : r_dig + 3'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + CW'(1);
        end
    end

    // Shadow holds the lit digit's pattern and duty steady for a whole slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_pat <= '0;
            r_cur_on  <= '0;
        end else if (w_slot_start) begin
            r_cur_pat <= r_file[r_dig];
            r_cur_on  <= w_on_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg_data   <= 8'h00;
            r_seg_com    <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg_data   <= w_seg_data_nx;
            r_seg_com    <= w_seg_com_nx;
            r_frame_tick <= bus.en && w_frame_end;
        end
    end

    assign bus.seg_data   = r_seg_data;
    assign bus.seg_com    = r_seg_com;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: fixed-timing probe table, hand-written
// corner sequences, and a randomized run against a time-position reference model.
module tb_seg_scan_driver;
    localparam int CLK_DIV = 40;
    localparam int BLANK   = 8;
    localparam int DIGITS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan_driver #(
        .CLK_DIV (CLK_DIV),
        .BLANK   (BLANK),
        .DIGITS  (DIGITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         k;
        logic [7:0] seg;
        logic [7:0] com;
        logic       tick;
    } probe_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         k;

    // Reference model: position p counts enabled cycles since the scan restarted.
    int         m_p;
    int         m_on;
    logic [7:0] m_file [8];
    logic [7:0] m_pat;
    logic [7:0] e_seg;
    logic [7:0] e_com;
    logic       e_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, k, act, exp);
        end
    endtask

    task automatic model_edge();
        int pos;
        int dig;
        logic [7:0] sel;
        if (!rst) begin
            m_p = 0; m_on = 0; m_pat = 8'h00;
            for (int i = 0; i < 8; i++) m_file[i] = 8'h00;
            e_seg = 8'h00; e_com = 8'hFF; e_tick = 1'b0;
        end else begin
            if (bus.en) begin
                pos = m_p % CLK_DIV;
                dig = (m_p / CLK_DIV) % DIGITS;
                if (pos == 0) begin
                    m_pat = m_file[dig];
                    m_on  = ((CLK_DIV - BLANK) / 8) * (int'(bus.bright) + 1);
                end
                sel    = 8'd1 << dig;
                e_seg  = (pos >= BLANK && pos < BLANK + m_on) ? m_pat : 8'h00;
                e_com  = (pos >= BLANK && pos < BLANK + m_on) ? ~sel : 8'hFF;
                e_tick = ((m_p % (CLK_DIV * DIGITS)) == CLK_DIV * DIGITS - 1);
                m_p++;
            end else begin
                m_p = 0;
                e_seg = 8'h00; e_com = 8'hFF; e_tick = 1'b0;
            end
            if (bus.wr_en && int'(bus.wr_addr) < DIGITS) m_file[bus.wr_addr] = bus.wr_data;
        end
    endtask

    // One clock: model follows the edge, DUT outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        k++;
        check("model_seg_data", bus.seg_data, e_seg);
        check("model_seg_com", bus.seg_com, e_com);
        check("model_frame_tick", bus.frame_tick, e_tick);
    endtask

    task automatic restart();
        bus.en = 1'b0;
        step();
        bus.en = 1'b1;
        k = 0;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        probe_t tbl[$];
        int     lit_cnt;
        int     tick_cnt;

        bus.en = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 8'h00; bus.bright = 3'd7;
        k = 0;
        #1 rst = 1'b0;

        // Reset held with scanning enabled and writes arriving.
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'($urandom_range(7));
            bus.wr_data = 8'($urandom);
            step();
            check("rst_seg_data", bus.seg_data, 8'h00);
            check("rst_seg_com", bus.seg_com, 8'hFF);
            check("rst_frame_tick", bus.frame_tick, 1'b0);
        end

        bus.wr_en = 1'b0; bus.en = 1'b0; bus.bright = 3'd7;
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'hFC;
        step();
        bus.wr_addr = 3'd1; bus.wr_data = 8'h60;
        step();
        bus.wr_en = 1'b0;
        step();
        bus.en = 1'b1;
        k = 0;

        // Basic scan and frame wrap, expected values worked out by hand.
        tbl.push_back('{8,   8'h00, 8'hFF, 1'b0});
        tbl.push_back('{9,   8'hFC, 8'hFE, 1'b0});
        tbl.push_back('{40,  8'hFC, 8'hFE, 1'b0});
        tbl.push_back('{41,  8'h00, 8'hFF, 1'b0});
        tbl.push_back('{48,  8'h00, 8'hFF, 1'b0});
        tbl.push_back('{49,  8'h60, 8'hFD, 1'b0});
        tbl.push_back('{80,  8'h60, 8'hFD, 1'b0});
        tbl.push_back('{81,  8'h00, 8'hFF, 1'b0});
        tbl.push_back('{89,  8'h00, 8'hFB, 1'b0});
        tbl.push_back('{129, 8'h00, 8'hF7, 1'b0});
        tbl.push_back('{159, 8'h00, 8'hF7, 1'b0});
        tbl.push_back('{160, 8'h00, 8'hF7, 1'b1});
        tbl.push_back('{161, 8'h00, 8'hFF, 1'b0});
        tbl.push_back('{169, 8'hFC, 8'hFE, 1'b0});
        foreach (tbl[i]) begin
            run_to(tbl[i].k);
            check("tbl_seg_data", bus.seg_data, tbl[i].seg);
            check("tbl_seg_com", bus.seg_com, tbl[i].com);
            check("tbl_frame_tick", bus.frame_tick, tbl[i].tick);
        end

        // Brightness drop mid-slot: digit 0 keeps its full window, digit 1 gets 4 cycles.
        restart();
        bus.bright = 3'd7;
        lit_cnt = 0;
        while (k < 40) begin
            if (k == 20) bus.bright = 3'd0;
            step();
            if (bus.seg_com !== 8'hFF) lit_cnt++;
        end
        check("bright_old_slot_lit", lit_cnt, 32);
        lit_cnt = 0;
        while (k < 80) begin
            step();
            if (bus.seg_com !== 8'hFF) lit_cnt++;
        end
        check("bright0_lit_cycles", lit_cnt, 4);
        check("bright0_dark_cycles", 40 - lit_cnt, 36);

        // Shadow coherence, ignored out-of-range write, write on the slot-start edge.
        restart();
        bus.bright = 3'd7;
        run_to(20);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'hDA;
        step();
        bus.wr_addr = 3'd5; bus.wr_data = 8'h11;
        step();
        bus.wr_en = 1'b0;
        run_to(30);
        check("shadow_same_slot", bus.seg_data, 8'hFC);
        run_to(49);
        check("addr5_ignored_seg", bus.seg_data, 8'h60);
        check("addr5_ignored_com", bus.seg_com, 8'hFD);
        run_to(160);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'h3C;
        step();
        bus.wr_en = 1'b0;
        run_to(169);
        check("shadow_next_visit", bus.seg_data, 8'hDA);
        check("shadow_next_visit_com", bus.seg_com, 8'hFE);
        run_to(329);
        check("edge_write_later", bus.seg_data, 8'h3C);

        // Frame marker spacing over an uninterrupted run.
        restart();
        tick_cnt = 0;
        for (int i = 0; i < 480; i++) begin
            step();
            if (bus.frame_tick === 1'b1) begin
                tick_cnt++;
                check("tick_position", k % 160, 0);
            end
        end
        check("tick_count", tick_cnt, 3);

        // Enable dropped mid-window, then restored.
        restart();
        run_to(20);
        check("abort_lit_before", bus.seg_com, 8'hFE);
        bus.en = 1'b0;
        step();
        check("abort_seg_data", bus.seg_data, 8'h00);
        check("abort_seg_com", bus.seg_com, 8'hFF);
        bus.en = 1'b1;
        k = 0;
        run_to(8);
        check("reenable_dark_k8", bus.seg_com, 8'hFF);
        step();
        check("reenable_lit_k9", bus.seg_com, 8'hFE);

        // Asynchronous reset mid-window.
        run_to(20);
        #2 rst = 1'b0;
        #1;
        check("async_rst_seg_data", bus.seg_data, 8'h00);
        check("async_rst_seg_com", bus.seg_com, 8'hFF);
        check("async_rst_frame_tick", bus.frame_tick, 1'b0);
        step();
        rst = 1'b1;
        k = 0;
        run_to(9);
        check("post_rst_file_clear", bus.seg_data, 8'h00);
        check("post_rst_digit0", bus.seg_com, 8'hFE);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.wr_en   = ($urandom_range(3) == 0);
            bus.wr_addr = 3'($urandom_range(7));
            bus.wr_data = 8'($urandom);
            if ($urandom_range(49) == 0) bus.bright = 3'($urandom_range(7));
            if (bus.en) bus.en = ($urandom_range(299) != 0);
            else        bus.en = ($urandom_range(3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for a multi-digit common-cathode 7-segment array. It sits directly downstream of the per-digit segment encoders, which emit 8-bit patterns in bit order a..g,dp with bit7 = a, active-high. It stores one pattern per digit, strobes one digit at a time with a blanking gap between digits, and applies a 3-bit brightness duty. It also emits a one-cycle frame marker for upstream logic that wants to update the array coherently.

## Interface
- CLK_DIV, default 1000: clock cycles per digit slot; legal range is CLK_DIV >= BLANK + 8.
- BLANK, default 16: blanking cycles at the start of each slot; legal range is BLANK >= 1.
- DIGITS, default 8: number of scanned digits, 1..8.
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- en, input, 1: scan enable; 0 blanks the array.
- wr_en, input, 1: pattern write strobe.
- wr_addr, input, 3: digit index for the write; writes with wr_addr >= DIGITS are ignored.
- wr_data, input, 8: segment pattern, a..g,dp, bit7 = a, active-high.
- bright, input, 3: brightness level 0..7.
- seg_data, output, 8: segment drive, active-high, registered.
- seg_com, output, 8: digit select, active-low, registered; bit i selects digit i.
- frame_tick, output, 1: one-cycle pulse at the end of the last digit's slot.

## Operation
- Pattern file: DIGITS x 8-bit registers, all cleared to 0 on reset.
  - A write with wr_en = 1 updates the file at the clock edge.
  - Writes are accepted regardless of en.
- Slot counter slot_cnt counts 0..CLK_DIV-1 and then wraps to 0.
  - At each wrap, digit index dig advances 0..DIGITS-1 and then wraps to 0.
- Slot start (slot_cnt = 0): the shadow register cur_pat latches file[dig] and cur_on latches on_len.
  - Both stay stable for the whole slot.
  - Writes during a slot do not affect the digit currently lit.
- on_len = ((CLK_DIV - BLANK) >> 3) * (bright + 1), computed unsigned at 16-bit width.
- Lit window: BLANK <= slot_cnt < BLANK + cur_on.
  - Inside the window: seg_data = cur_pat and seg_com = ~(1 << dig).
  - Outside the window: seg_data = 0 and seg_com = 8'hFF.
- Exactly one seg_com bit is low at any time, or none. Bits at or above DIGITS are always 1.
- frame_tick = 1 in the cycle after the edge where slot_cnt = CLK_DIV-1 and dig = DIGITS-1. Otherwise it is 0.
- en = 0:
  - slot_cnt, dig and frame_tick are forced to 0 synchronously.
  - Outputs are blanked on the next edge.
- en 0 -> 1: scanning restarts at digit 0, slot_cnt 0, with a fresh shadow latch.
- Reset, asynchronous at any time including mid-slot:
  - seg_data = 8'h00, seg_com = 8'hFF, frame_tick = 0.
  - slot_cnt = 0, dig = 0, cur_pat = 0, cur_on = 0, pattern file cleared.
- Simultaneous write to file[dig] at the slot-start edge: the shadow latches the OLD value, and the new value is shown on the next visit.

## Timing
- Outputs are registered with 1-cycle latency from counter state.
- Let edge E0 be the edge where slot_cnt becomes 0. Then seg_com goes low at edge E0 + BLANK + 1 and returns to 8'hFF at edge E0 + BLANK + cur_on + 1.
- Slot period is CLK_DIV cycles; frame period is DIGITS x CLK_DIV cycles.
- First lit cycle after reset release with en = 1 is BLANK + 1 edges later, showing digit 0.
- No combinational path from any input to any output.

## Test plan
Use CLK_DIV = 40, BLANK = 8, DIGITS = 4 (quantum 4).
- **Reset:** hold rst = 0 with en = 1 and random writes -> seg_data = 8'h00, seg_com = 8'hFF, frame_tick = 0 throughout.
- **Basic scan:** write file0 = 8'hFC, file1 = 8'h60, bright = 7, en = 1.
  - Digit 0: seg_com = 8'hFE with seg_data = 8'hFC for 32 cycles, starting 9 edges after slot start.
  - Digit 1: seg_com = 8'hFD with seg_data = 8'h60 for 32 cycles, starting 40 cycles after digit 0's start.
- **Brightness:** bright = 0 -> lit window is 4 cycles per slot, with 36 cycles of 8'hFF per slot. Changing bright mid-slot takes effect only in the next slot.
- **Frame wrap:** frame_tick pulses once every 160 cycles, exactly one cycle after digit 3's slot ends. The next lit digit is 0.
- **Shadow coherence:** write file0 = 8'hDA during digit 0's lit window -> digit 0 still shows 8'hFC for that slot, and shows 8'hDA 160 cycles later. A write to wr_addr = 5 has no effect.
- **Mid-operation abort:**
  - Deassert en mid-window -> next edge gives seg_com = 8'hFF, seg_data = 0.
  - Reassert en -> digit 0 lights after 9 edges.
  - Asserting rst mid-window -> outputs go to reset values immediately, asynchronously, and the pattern file reads 0 afterwards.
